associative_cache_16: RTL and testbench
=======================================

Name: associative_cache_16

Overview:
- Byte-addressable, fully associative read cache in front of a 4 KiB backing memory (12-bit physical address).
- Memory is 256 lines x 16 bytes; the cache holds 16 blocks x 16 bytes.
- Any memory line may occupy any block. Each lookup returns the full 128-bit line, the addressed byte and a hit flag.
- Standalone read-path block; the backing memory is internal and read-only.

Parameters:
- none. Geometry is fixed: 12-bit address, 8-bit tag addr[11:4], 4-bit byte offset addr[3:0], 16 blocks, 128-bit line.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- addr  input  12  byte address; tag = addr[11:4], offset = addr[3:0].
- enable  input  1  lookup request, sampled on rising clk.
- line  output  128  registered line data; byte k occupies line[8k+7:8k].
- hit  output  1  registered; 1 = last lookup hit, 0 = miss or no lookup since reset.
- ByTe  output  8  registered addressed byte, equal to line[8*offset+7 : 8*offset].

Behaviour:
- Backing memory:
  - 256 lines, contents fixed (ROM-like, synthesizable constant function).
  - Byte k of memory line T = (T + k) mod 256.
- Storage per block: valid bit, 8-bit tag, 128-bit data. Plus one 4-bit FIFO replacement pointer.
- Reset (asynchronous, rst=1):
  - All valid bits cleared; FIFO pointer = 0.
  - line = 0, ByTe = 0, hit = 0.
  - Takes effect immediately and overrides any lookup in progress. Tag and data arrays need not be cleared.
- enable=0 at a rising edge: no state change; line, ByTe and hit hold their previous values.
- enable=1 at a rising edge: compare tag against all 16 blocks in parallel; match requires valid && tag equal.
- Hit:
  - hit <= 1; line <= matching block data; ByTe <= selected byte.
  - No replacement-state change (FIFO, not LRU).
- Miss:
  - hit <= 0. Fetch memory line tag into a victim block; set its valid bit and store the tag.
  - line <= fetched data; ByTe <= selected byte of the fetched data.
  - Victim choice: lowest-index invalid block if any exists; otherwise the block at the FIFO pointer.
  - FIFO pointer increments (mod 16) only when a valid block is evicted.
- Latency: one cycle. Outputs reflect the lookup sampled at the previous rising edge. Fill completes in the same edge; no stall or handshake.
- Back-to-back lookups are allowed every cycle. A lookup to a line filled in the previous cycle must hit.
- At most one block may match; the allocation rules guarantee tag uniqueness.
- Any addr offset 0..15 is legal; there is no alignment requirement.

Test Plan:
- Reset then idle: assert rst for 2 cycles with enable=0 -> line=0, ByTe=0x00, hit=0; outputs stay 0 while enable=0.
- Cold miss: addr=0x000, enable=1 for one edge -> hit=0, line=0x0F0E0D0C0B0A09080706050403020100, ByTe=0x00.
- Hold on disable: next edge, addr=0x01F with enable=0 -> line, ByTe and hit unchanged from the previous scenario.
- Miss then hit:
  - addr=0x01F, enable=1 -> hit=0, ByTe=0x10, line bytes 0x01..0x10.
  - Then addr=0x013 -> hit=1, ByTe=0x04.
  - Then addr=0x000 -> hit=1, ByTe=0x00.
- FIFO eviction:
  - After reset, look up tags 0x00..0x0F (offset 0) -> all miss.
  - Re-access tag 0x05 -> hit=1.
  - Access tag 0x10 -> miss, evicts tag 0x00 (block 0).
  - Access tag 0x00 -> miss, evicts tag 0x01.
  - Access tag 0x05 -> still hit=1.
- Async reset mid-operation: pulse rst between clock edges after a fill -> outputs clear immediately; next lookup of the same address returns hit=0.

Source files
------------

// File: rtl/associative_cache_16.sv
// Fully associative 16-block read cache over a fixed 256-line x 16-byte backing ROM.
// One-cycle lookup; misses fill lowest invalid block first, then evict in FIFO order.
module associative_cache_16 (
    input  logic         clk,
    input  logic         rst,
    input  logic [11:0]  addr,
    input  logic         enable,
    output logic [127:0] line,
    output logic         hit,
    output logic [7:0]   ByTe
);

    localparam int unsigned NBLK   = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned OFF_W  = 4;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned BYTE_W = 8;

    // Backing ROM: byte k of line t is (t + k) mod 256
    function automatic logic [LINE_W-1:0] mem_line(input logic [TAG_W-1:0] t);
        logic [LINE_W-1:0] d;
        d = '0;
        for (int k = 0; k < 16; k++) begin
            d[k*BYTE_W +: BYTE_W] = t + 8'(k);
        end
        return d;
    endfunction

    logic [NBLK-1:0]    valid;
    logic [TAG_W-1:0]   tags [NBLK];
    logic [LINE_W-1:0]  data [NBLK];
    logic [IDX_W-1:0]   fifo_ptr;

    logic [TAG_W-1:0]   tag;
    logic [OFF_W-1:0]   offset;
    logic               match;
    logic [IDX_W-1:0]   match_idx;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   victim;
    logic [LINE_W-1:0]  fill_data;
    logic [LINE_W-1:0]  sel_data;
    logic [BYTE_W-1:0]  sel_byte;

    assign tag    = addr[11:4];
    assign offset = addr[3:0];

    // Parallel tag compare, lowest-free search and output selection
    always_comb begin
        match      = 1'b0;
        match_idx  = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < NBLK; i++) begin
            if (valid[i] && (tags[i] == tag)) begin
                match     = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
        for (int i = NBLK - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        victim    = free_found ? free_idx : fifo_ptr;
        fill_data = mem_line(tag);
        sel_data  = match ? data[match_idx] : fill_data;
        sel_byte  = sel_data[{offset, 3'b000} +: BYTE_W];
    end

    // Control state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= '0;
            fifo_ptr <= '0;
            line     <= '0;
            hit      <= 1'b0;
            ByTe     <= '0;
        end else if (enable) begin
            hit  <= match;
            line <= sel_data;
            ByTe <= sel_byte;
            if (!match) begin
                valid[victim] <= 1'b1;
                if (!free_found) begin
                    fifo_ptr <= IDX_W'(fifo_ptr + 1'b1);
                end
            end
        end
    end

    // Tag/data arrays carry no reset; validity is tracked separately
    always_ff @(posedge clk) begin
        if (!rst && enable && !match) begin
            tags[victim] <= tag;
            data[victim] <= fill_data;
        end
    end

endmodule

// File: tb/tb_associative_cache_16.sv
// Self-checking bench for associative_cache_16: directed vector table, FIFO and
// async-reset sequences, and randomized lookups against a tag-queue reference model.
module tb_associative_cache_16;

    logic         clk = 1'b0;
    logic         rst;
    logic [11:0]  addr;
    logic         enable;
    logic [127:0] line;
    logic         hit;
    logic [7:0]   ByTe;

    always #5 clk = ~clk;

    associative_cache_16 dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .enable (enable),
        .line   (line),
        .hit    (hit),
        .ByTe   (ByTe)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: resident tags in insertion order, capacity 16
    logic [7:0]   q [$];
    logic         m_hit;
    logic [127:0] m_line;
    logic [7:0]   m_byte;

    typedef struct {
        logic         en;
        logic [11:0]  a;
        logic         e_hit;
        logic [7:0]   e_byte;
        logic [127:0] e_line;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [127:0] mem_ref(input int t);
        logic [127:0] d;
        for (int k = 0; k < 16; k++) begin
            d[k*8 +: 8] = 8'((t + k) % 256);
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_hit  = 1'b0;
        m_line = '0;
        m_byte = '0;
    endtask

    task automatic model_step(input logic en, input logic [11:0] a);
        int  t;
        bit  found;
        if (en) begin
            t = int'(a[11:4]);
            found = 1'b0;
            foreach (q[i]) if (int'(q[i]) == t) found = 1'b1;
            if (!found) begin
                if (q.size() == 16) void'(q.pop_front());
                q.push_back(8'(t));
            end
            m_hit  = found;
            m_line = mem_ref(t);
            m_byte = 8'((t + int'(a[3:0])) % 256);
        end
    endtask

    task automatic drive(input logic en, input logic [11:0] a);
        @(negedge clk);
        enable = en;
        addr   = a;
        @(posedge clk);
        #1;
        model_step(en, a);
    endtask

    task automatic check_model(input string name);
        chk({name, " hit"},  128'(hit),  128'(m_hit));
        chk({name, " line"}, line,       m_line);
        chk({name, " byte"}, 128'(ByTe), 128'(m_byte));
    endtask

    // Lookup with an explicitly required hit flag plus model data check
    task automatic step_exp(input logic [11:0] a, input logic e_hit, input string name);
        drive(1'b1, a);
        chk({name, " hit"}, 128'(hit), 128'(e_hit));
        chk({name, " line"}, line, m_line);
        chk({name, " byte"}, 128'(ByTe), 128'(m_byte));
    endtask

    task automatic check_zero(input string name);
        chk({name, " hit"},  128'(hit),  128'(0));
        chk({name, " line"}, line,       128'(0));
        chk({name, " byte"}, 128'(ByTe), 128'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic pulse_reset(input string name);
        @(negedge clk);
        enable = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_zero(name);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        addr   = '0;
        model_reset();

        vecs[0] = '{1'b1, 12'h000, 1'b0, 8'h00, 128'h0F0E0D0C0B0A09080706050403020100};
        vecs[1] = '{1'b0, 12'h01F, 1'b0, 8'h00, 128'h0F0E0D0C0B0A09080706050403020100};
        vecs[2] = '{1'b1, 12'h01F, 1'b0, 8'h10, 128'h100F0E0D0C0B0A090807060504030201};
        vecs[3] = '{1'b1, 12'h013, 1'b1, 8'h04, 128'h100F0E0D0C0B0A090807060504030201};
        vecs[4] = '{1'b1, 12'h000, 1'b1, 8'h00, 128'h0F0E0D0C0B0A09080706050403020100};

        // Reset then idle
        do_reset();
        repeat (2) begin
            drive(1'b0, 12'hABC);
            check_zero("idle");
        end

        // Directed vector table
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].en, vecs[i].a);
            chk($sformatf("vec%0d hit", i),  128'(hit),  128'(vecs[i].e_hit));
            chk($sformatf("vec%0d line", i), line,       vecs[i].e_line);
            chk($sformatf("vec%0d byte", i), 128'(ByTe), 128'(vecs[i].e_byte));
        end

        // FIFO eviction order
        do_reset();
        for (int t = 0; t < 16; t++) step_exp({8'(t), 4'h0}, 1'b0, $sformatf("fill%0d", t));
        step_exp(12'h050, 1'b1, "reuse05");
        step_exp(12'h100, 1'b0, "new10");
        step_exp(12'h000, 1'b0, "refetch00");
        step_exp(12'h05A, 1'b1, "keep05");
        step_exp(12'h10F, 1'b1, "keep10");
        step_exp(12'h003, 1'b1, "keep00");
        step_exp(12'h017, 1'b0, "evicted01");

        // Async reset between edges after a fill
        do_reset();
        step_exp(12'h123, 1'b0, "prefill");
        step_exp(12'h12F, 1'b1, "prehit");
        pulse_reset("async");
        step_exp(12'h123, 1'b0, "postrst");

        // Randomized lookups against the reference model
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic        en;
            logic [11:0] a;
            en = ($urandom_range(0, 3) != 0);
            a  = {8'($urandom_range(0, 23)), 4'($urandom_range(0, 15))};
            drive(en, a);
            check_model($sformatf("rand%0d", n));
            if (n % 500 == 499) pulse_reset($sformatf("rrst%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
